// File: rtl/mult4_arb_pkg.sv
// Shared constants and output-stage state type for the shared 4-bit multiplier arbiter.
package mult4_arb_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned PROD_W = 8;

    typedef enum logic {
        ST_EMPTY,
        ST_FULL
    } state_e;

endpackage

// File: rtl/multiplier_4bits_version7.sv
// Combinational unsigned 4x4 multiplier built from shifted partial products.
module multiplier_4bits_version7
    import mult4_arb_pkg::*;
(
    input  logic [OP_W-1:0]   i_a,
    input  logic [OP_W-1:0]   i_b,
    output logic [PROD_W-1:0] o_product
);

    logic [PROD_W-1:0] w_sum;

    always_comb begin
        w_sum = '0;
        for (int unsigned k = 0; k < OP_W; k++) begin
            if (i_b[k]) begin
                w_sum = w_sum + (PROD_W'(i_a) << k);
            end
        end
    end

    assign o_product = w_sum;

endmodule

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or above the pointer, wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    int unsigned w_j;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_j   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_j = (32'(i_ptr) + k) % NUM_REQ;
            if (!o_any && i_req[w_j]) begin
                o_any      = 1'b1;
                o_gnt[w_j] = 1'b1;
                o_idx      = ID_W'(w_j);
            end
        end
    end

endmodule

// File: rtl/mult4_share_arbiter.sv
// Round-robin arbiter sharing one combinational 4-bit multiplier across NUM_REQ
// requesters, with a one-entry registered result stage carrying the requester id.
module mult4_share_arbiter
    import mult4_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*OP_W-1:0] req_a,
    input  logic [NUM_REQ*OP_W-1:0] req_b,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [ID_W-1:0]         resp_id,
    output logic [PROD_W-1:0]       resp_product
);

    state_e            r_state;
    state_e            w_state_next;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   r_id;
    logic [PROD_W-1:0] r_product;
    logic [ID_W-1:0]   w_ptr_next;
    logic [ID_W-1:0]   w_idx;
    logic [NUM_REQ-1:0] w_gnt;
    logic              w_any;
    logic              w_can_accept;
    logic              w_xfer;
    logic [OP_W-1:0]   w_a;
    logic [OP_W-1:0]   w_b;
    logic [PROD_W-1:0] w_product;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // Only the winner's operands reach the single multiplier instance.
    assign w_a = req_a[32'(w_idx) * OP_W +: OP_W];
    assign w_b = req_b[32'(w_idx) * OP_W +: OP_W];

    multiplier_4bits_version7 u_mult (
        .i_a       (w_a),
        .i_b       (w_b),
        .o_product (w_product)
    );

    // A full stage being drained this cycle can refill on the same edge.
    assign w_can_accept = (r_state == ST_EMPTY) || resp_ready;
    assign w_xfer       = rst_n && w_can_accept && w_any;
    assign req_ready    = w_xfer ? w_gnt : '0;
    assign w_ptr_next   = (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_xfer) begin
            w_state_next = ST_FULL;
        end else if (r_state == ST_FULL && resp_ready) begin
            w_state_next = ST_EMPTY;
        end
    end

    always_comb begin
        resp_valid = (r_state == ST_FULL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr     <= '0;
            r_id      <= '0;
            r_product <= '0;
        end else if (w_xfer) begin
            r_ptr     <= w_ptr_next;
            r_id      <= w_idx;
            r_product <= w_product;
        end
    end

    assign resp_id      = r_id;
    assign resp_product = r_product;

endmodule
